// File: rtl/niosii_pio_key_in.sv
// niosii_pio_key_in -- Avalon-MM slave parallel input port (push-buttons/switches).
//
// Samples an asynchronous input bus through a flop synchroniser, detects the
// configured edge type into a sticky, write-1-to-clear capture register and
// raises a maskable level interrupt.
//
// Optional feature macro: PIO_KEY_DEBOUNCE_EN
//   defined   : per-bit stable-count debounce filter between the synchroniser
//               and the edge detector / data register
//   undefined : synchroniser output is used directly
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   address[1:0]          word address: 0 data, 1 reserved, 2 irq_mask, 3 edge_capture
//   chipselect            slave select
//   read_n, write_n       active-low strobes
//   writedata[31:0]       write data
//   in_port[DATA_WIDTH]   asynchronous external inputs
//   readdata[31:0]        registered read data (latency 1)
//   irq                   registered level interrupt, active-high
module niosii_pio_key_in #(
  parameter int DATA_WIDTH      = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam int BW = $clog2(SYNC_STAGES + 2);
  localparam logic [BW-1:0] BLANK_INIT = BW'(SYNC_STAGES + 1);

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_in;
  logic [DATA_WIDTH-1:0] filt;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic [DATA_WIDTH-1:0] rising, falling, edges;
  logic [BW-1:0]         blank_q, blank_d;
  logic [31:0]           readdata_q, readdata_d;
  logic                  irq_q, irq_d;
  logic                  wr_en, rd_en;
  logic [31:0]           unused_wd;

  // Only the low DATA_WIDTH bits of writedata are meaningful.
  assign unused_wd = writedata;

  assign sync_in = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = in_port;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

`ifdef PIO_KEY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DATA_WIDTH-1:0] filt_q, filt_d;
  logic [CW-1:0]         dcnt_q [DATA_WIDTH];
  logic [CW-1:0]         dcnt_d [DATA_WIDTH];

  // Counter runs only while the input disagrees with the filtered value; any
  // return to agreement restarts it, so only a steady change is accepted.
  always_comb begin
    filt_d = filt_q;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      dcnt_d[i] = '0;
      if (sync_in[i] != filt_q[i]) begin
        if (dcnt_q[i] == CW'(DEBOUNCE_CYCLES)) begin
          filt_d[i] = sync_in[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) dcnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_in;
`endif

  // Edge detection is suppressed while the blanking counter is non-zero so
  // the reset-to-live transition of the sampling flops is never captured.
  always_comb begin
    rising  = filt & ~prev_q;
    falling = ~filt & prev_q;
    case (EDGE_TYPE)
      0:       edges = rising;
      1:       edges = falling;
      default: edges = rising | falling;
    endcase
    if (blank_q != '0) edges = '0;
  end

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & ~read_n;

  always_comb begin
    prev_d  = filt;
    blank_d = (blank_q != '0) ? blank_q - 1'b1 : blank_q;

    mask_d = mask_q;
    if (wr_en && address == 2'd2) mask_d = writedata[DATA_WIDTH-1:0];

    // Clear is applied first so a same-cycle edge re-sets the bit.
    cap_d = cap_q;
    if (wr_en && address == 2'd3) cap_d = cap_q & ~writedata[DATA_WIDTH-1:0];
    cap_d = cap_d | edges;

    // Reads use current (pre-write) register values.
    readdata_d = readdata_q;
    if (rd_en) begin
      readdata_d = '0;
      case (address)
        2'd0:    readdata_d[DATA_WIDTH-1:0] = filt;
        2'd2:    readdata_d[DATA_WIDTH-1:0] = mask_q;
        2'd3:    readdata_d[DATA_WIDTH-1:0] = cap_q;
        default: ;
      endcase
    end

    irq_d = |(cap_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q     <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      blank_q    <= BLANK_INIT;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      blank_q    <= blank_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_niosii_pio_key_in.sv
// Directed self-checking bench for niosii_pio_key_in (DATA_WIDTH=4,
// EDGE_TYPE=1 falling, SYNC_STAGES=2, DEBOUNCE_CYCLES=8).
module tb_niosii_pio_key_in;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
`ifdef PIO_KEY_DEBOUNCE_EN
  localparam int LAT = SYNC + 1 + DEB + 1;
`else
  localparam int LAT = SYNC + 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = 4'hF;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  niosii_pio_key_in #(
    .DATA_WIDTH(4),
    .EDGE_TYPE(1),
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .read_n(read_n),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1; in_port = 4'hF;
    wait_cycles(2);
    n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got %h want %h", readdata, 32'h0); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    reset = 1'b0;
    for (int i = 0; i < LAT + 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL blank_irq cycle %0d got %b want 0", i, irq); end
    end
    bus_read(2'd0, d);
    n_checks++;
    if (d !== 32'h0000_000F) begin n_fail++; $display("FAIL read_data got %h want %h", d, 32'hF); end
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL read_mask got %h want 0", d); end
    bus_read(2'd3, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL read_capture got %h want 0", d); end
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL read_reserved got %h want 0", d); end
  endtask

  task automatic test_regs;
    logic [31:0] d;
    bus_write(2'd2, 32'hFFFF_FFF5);
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h5) begin n_fail++; $display("FAIL mask_width got %h want 5", d); end
    bus_write(2'd0, 32'h0);
    bus_read(2'd0, d);
    n_checks++;
    if (d !== 32'hF) begin n_fail++; $display("FAIL data_ro got %h want F", d); end
    // simultaneous read+write returns pre-write data
    address = 2'd2; writedata = 32'hA; chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    n_checks++;
    if (readdata !== 32'h5) begin n_fail++; $display("FAIL rw_prewrite got %h want 5", readdata); end
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'hA) begin n_fail++; $display("FAIL rw_postwrite got %h want A", d); end
  endtask

  task automatic test_falling_irq;
    logic [31:0] d;
    bus_write(2'd2, 32'h2);
    address = 2'd3; chipselect = 1'b1; read_n = 1'b0;
    in_port = 4'hD;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (readdata !== ((k >= LAT + 1) ? 32'h2 : 32'h0)) begin
        n_fail++; $display("FAIL cap_latency k=%0d got %h want %h", k, readdata, (k >= LAT + 1) ? 32'h2 : 32'h0);
      end
      n_checks++;
      if (irq !== (k >= LAT + 1)) begin
        n_fail++; $display("FAIL irq_latency k=%0d got %b want %b", k, irq, (k >= LAT + 1));
      end
    end
    chipselect = 1'b0; read_n = 1'b1;
    bus_write(2'd3, 32'h2);
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b want 0", irq); end
    bus_read(2'd3, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL cap_clear got %h want 0", d); end
  endtask

  task automatic test_mask;
    logic [31:0] d;
    bus_write(2'd2, 32'h0);
    in_port = 4'hC;
    wait_cycles(LAT + 2);
    bus_read(2'd3, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL masked_cap got %h want 1", d); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL masked_irq got %b want 0", irq); end
    bus_write(2'd2, 32'h1);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL unmask_lag got %b want 0", irq); end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL unmask_irq got %b want 1", irq); end
    bus_write(2'd3, 32'h1);
  endtask

  task automatic test_set_wins;
    logic [31:0] d;
    in_port = 4'h8;
    wait_cycles(LAT - 1);
    address = 2'd3; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    bus_read(2'd3, d);
    n_checks++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL set_wins got %h want 4", d); end
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL second_clear got %h want 0", d); end
  endtask

  task automatic test_reset_midop;
    logic [31:0] d;
    bus_write(2'd2, 32'hF);
    in_port = 4'hF;
    wait_cycles(LAT + 2);
    in_port = 4'h0;
    wait_cycles(LAT + 2);
    bus_read(2'd3, d);
    n_checks++;
    if (d !== 32'hF) begin n_fail++; $display("FAIL pre_reset_cap got %h want F", d); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq got %b want 1", irq); end
    reset = 1'b1; in_port = 4'hF;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL midrst_readdata got %h want 0", readdata); end
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq cycle %0d got %b want 0", i, irq); end
    end
    bus_read(2'd3, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_cap got %h want 0", d); end
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_mask got %h want 0", d); end
  endtask

`ifdef PIO_KEY_DEBOUNCE_EN
  task automatic test_debounce;
    logic [31:0] d;
    in_port = 4'hF;
    wait_cycles(20);
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h8);
    in_port = 4'h7;
    wait_cycles(5);
    in_port = 4'hF;
    wait_cycles(20);
    bus_read(2'd3, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_cap got %h want 0", d); end
    address = 2'd3; chipselect = 1'b1; read_n = 1'b0;
    in_port = 4'h7;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k >= LAT) begin
        n_checks++;
        if (readdata !== ((k == LAT + 1) ? 32'h8 : 32'h0)) begin
          n_fail++; $display("FAIL deb_cap k=%0d got %h want %h", k, readdata, (k == LAT + 1) ? 32'h8 : 32'h0);
        end
        n_checks++;
        if (irq !== (k == LAT + 1)) begin
          n_fail++; $display("FAIL deb_irq k=%0d got %b want %b", k, irq, (k == LAT + 1));
        end
      end
    end
    chipselect = 1'b0; read_n = 1'b1;
    wait_cycles(10);
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_regs();
    test_falling_irq();
    test_mask();
    test_set_wins();
    test_reset_midop();
`ifdef PIO_KEY_DEBOUNCE_EN
    test_debounce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
